exception_arbiter: RTL

//  Requester side of the CP0 exception interface: collects syscall/break/trap pulses from decode and

---
 rtl/exception_arbiter_pkg.sv | 26 ++
 rtl/exception_arbiter_if.sv | 38 +++
 rtl/exception_arbiter_irq_sync.sv | 28 ++
 rtl/exception_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/exception_arbiter_pkg.sv
// Shared types for the exception arbiter slice.
// Contents:
//   DATA_WIDTH        default PC/data width
//   exc_code_e        cause codes presented to CP0 (EXC_NONE when nothing is presented)
//   exc_arb_state_e   arbiter FSM states
package exception_arbiter_pkg;

  localparam int DATA_WIDTH = 32;

  // Encodings follow the MIPS Cause.ExcCode field; EXC_NONE is an unused
  // encoding that marks "no request presented".
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_TR   = 5'd13,
    EXC_NONE = 5'd31
  } exc_code_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } exc_arb_state_e;

endpackage

// File: rtl/exception_arbiter_if.sv
// Bundle between decode/CP0 and the exception arbiter.
// Parameters: IrqCount (external interrupt lines), Width (PC width).
// Modports:
//   master - decode/CP0 side: drives enable, sysReq, bpReq, trReq, instrPc, irq,
//            excAck, eret; observes excValid, excCode, excPc, stall, busy
//   slave  - the arbiter: the mirror image
interface exception_arbiter_if
  import exception_arbiter_pkg::*;
#(
  parameter int IrqCount = 6,
  parameter int Width    = DATA_WIDTH
);

  logic                enable;
  logic                sysReq;
  logic                bpReq;
  logic                trReq;
  logic [Width-1:0]    instrPc;
  logic [IrqCount-1:0] irq;
  logic                excAck;
  logic                eret;
  logic                excValid;
  exc_code_e           excCode;
  logic [Width-1:0]    excPc;
  logic                stall;
  logic                busy;

  modport master (
    output enable, sysReq, bpReq, trReq, instrPc, irq, excAck, eret,
    input  excValid, excCode, excPc, stall, busy
  );

  modport slave (
    input  enable, sysReq, bpReq, trReq, instrPc, irq, excAck, eret,
    output excValid, excCode, excPc, stall, busy
  );

endinterface

// File: rtl/exception_arbiter_irq_sync.sv
// irq_synchronizer: two-flop synchroniser for the external interrupt lines.
// Ports:
//   clock, reset (async, active-high), enable (freezes both stages when 0)
//   irq_in  - asynchronous interrupt lines
//   irq_out - lines after two register stages
module irq_synchronizer #(
  parameter int IrqCount = 6
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [IrqCount-1:0] irq_in,
  output logic [IrqCount-1:0] irq_out
);

  logic [IrqCount-1:0] meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta    <= '0;
      irq_out <= '0;
    end else if (enable) begin
      meta    <= irq_in;
      irq_out <= meta;
    end
  end

endmodule

// File: rtl/exception_arbiter.sv
// exception_arbiter: requester side of the CP0 exception interface.
// Collects SYSCALL/BREAK/trap pulses and external interrupt levels, picks one
// by priority (Sys > Bp > Tr > Int) and presents its cause and PC to CP0.
// CP0's eJump (excAck) acknowledges a request; ERET ends service.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous, active-high
//   bus    - exception_arbiter_if.slave (inputs: enable, sysReq, bpReq, trReq,
//            instrPc, irq, excAck, eret; outputs: excValid, excCode, excPc,
//            stall, busy)
// Configuration macro:
//   EXC_IRQ_SYNC_EN - when defined, irq passes through a two-flop synchroniser
//                     (irq_synchronizer) before it is used; otherwise irq must
//                     already be synchronous to clock.
module exception_arbiter
  import exception_arbiter_pkg::*;
#(
  parameter int IrqCount = 6,
  parameter int Width    = DATA_WIDTH
) (
  input logic                 clock,
  input logic                 reset,
  exception_arbiter_if.slave  bus
);

  logic [IrqCount-1:0] irq_s;

`ifdef EXC_IRQ_SYNC_EN
  irq_synchronizer #(.IrqCount(IrqCount)) u_irq_sync (
    .clock   (clock),
    .reset   (reset),
    .enable  (bus.enable),
    .irq_in  (bus.irq),
    .irq_out (irq_s)
  );
`else
  assign irq_s = bus.irq;
`endif

  // Interrupts are a level, never latched: re-evaluated every cycle.
  logic int_p;
  assign int_p = |irq_s;

  logic             sys_p, bp_p, tr_p;
  logic [Width-1:0] sys_pc, bp_pc, tr_pc;
  exc_arb_state_e   state;
  logic             exc_valid;
  exc_code_e        exc_code;
  logic [Width-1:0] exc_pc;

  // Winner of the registered pending set; Int takes the live instrPc.
  exc_code_e        win_code;
  logic [Width-1:0] win_pc;
  logic             any_req;

  always_comb begin
    win_code = EXC_INT;
    win_pc   = bus.instrPc;
    if (sys_p) begin
      win_code = EXC_SYS;
      win_pc   = sys_pc;
    end else if (bp_p) begin
      win_code = EXC_BP;
      win_pc   = bp_pc;
    end else if (tr_p) begin
      win_code = EXC_TR;
      win_pc   = tr_pc;
    end
  end

  assign any_req = sys_p | bp_p | tr_p | int_p;

  // Leaving REQUEST clears the presented synchronous source whether or not it
  // was acknowledged (an unacked synchronous request is discarded).
  logic clr_sys, clr_bp, clr_tr;
  assign clr_sys = (state == REQUEST) && (exc_code == EXC_SYS);
  assign clr_bp  = (state == REQUEST) && (exc_code == EXC_BP);
  assign clr_tr  = (state == REQUEST) && (exc_code == EXC_TR);

  // A new pulse beats a same-cycle clear; a pulse on a source that stays
  // pending is ignored so the first PC is kept.
  logic sys_keep, bp_keep, tr_keep;
  assign sys_keep = sys_p & ~clr_sys;
  assign bp_keep  = bp_p  & ~clr_bp;
  assign tr_keep  = tr_p  & ~clr_tr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sys_p     <= 1'b0;
      bp_p      <= 1'b0;
      tr_p      <= 1'b0;
      sys_pc    <= '0;
      bp_pc     <= '0;
      tr_pc     <= '0;
      exc_valid <= 1'b0;
      exc_code  <= EXC_NONE;
      exc_pc    <= '0;
    end else if (bus.enable) begin
      sys_p <= sys_keep | bus.sysReq;
      bp_p  <= bp_keep  | bus.bpReq;
      tr_p  <= tr_keep  | bus.trReq;
      if (bus.sysReq && !sys_keep) sys_pc <= bus.instrPc;
      if (bus.bpReq  && !bp_keep)  bp_pc  <= bus.instrPc;
      if (bus.trReq  && !tr_keep)  tr_pc  <= bus.instrPc;

      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= REQUEST;
            exc_valid <= 1'b1;
            exc_code  <= win_code;
            exc_pc    <= win_pc;
          end
        end
        REQUEST: begin
          exc_valid <= 1'b0;
          exc_code  <= EXC_NONE;
          state     <= bus.excAck ? SERVICE : IDLE;
        end
        SERVICE: begin
          if (bus.eret) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.excValid = exc_valid;
  assign bus.excCode  = exc_code;
  assign bus.excPc    = exc_pc;
  assign bus.stall    = sys_p | bp_p | tr_p | (exc_valid & (exc_code != EXC_INT));
  assign bus.busy     = (state == SERVICE);

endmodule
